// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling constants, frame format.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    // Frame format shared by uart_tx and uart_rx: 1 start bit low, 1 stop bit high.
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam int   STOP_BITS   = 1;

    function automatic logic parity_of(input logic [8:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Write-side bundle between the UART receiver and its downstream FIFO.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);

    logic [DATA_BITS-1:0] data_out;
    logic                 wr_en;
    logic                 fifo_full;

    modport master (
        output data_out,
        output wr_en,
        input  fifo_full
    );

    modport slave (
        input  data_out,
        input  wr_en,
        output fifo_full
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIVISOR clocks, held at 0 by clear.
module uart_baud_tick #(
    parameter int DIVISOR = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q + CW'(1);
        if (clear || count_q == LAST) begin
            count_d = '0;
        end
    end

    assign tick = !clear && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver feeding a FIFO write port.
// Parity bit support is compiled in with `define UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIVISOR    = 27,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    uart_rx_if.master   fifo,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun_err,
    output logic        parity_err
);

    localparam logic [3:0] MID_LAST = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] BIT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    uart_state_e state_q, state_d;

    logic sync1_q, sync2_q, prev_q;
    logic rx_s;
    logic tick;

    logic [3:0]           sample_q, sample_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;

    logic wr_q, wr_d;
    logic busy_q, busy_d;
    logic ferr_q, ferr_d;
    logic oerr_q, oerr_d;
    logic perr_q, perr_d;
    logic par_bad;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic par_exp;
`endif

    assign rx_s = sync2_q;

    uart_baud_tick #(
        .DIVISOR(DIVISOR)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state_q == IDLE),
        .tick (tick)
    );

`ifdef UART_RX_PARITY_EN
    assign par_exp = parity_of(9'(shift_q)) ^ PARITY_ODD[0];
    assign par_bad = (par_q != par_exp);
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = data_q;
        wr_d     = 1'b0;
        ferr_d   = 1'b0;
        oerr_d   = 1'b0;
        perr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Only a true 1->0 transition starts a frame; a stuck-low line does not.
                if (prev_q == STOP_LEVEL && rx_s == START_LEVEL) begin
                    sample_d = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (tick) begin
                    sample_d = sample_q + 4'd1;
                    if (sample_q == MID_LAST) begin
                        if (rx_s != START_LEVEL) begin
                            state_d = IDLE;
                        end else begin
                            sample_d = '0;
                            bit_d    = '0;
                            state_d  = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sample_d = sample_q + 4'd1;
                    if (sample_q == BIT_LAST) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    sample_d = sample_q + 4'd1;
                    if (sample_q == BIT_LAST) begin
                        par_d   = rx_s;
                        state_d = STOP;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    sample_d = sample_q + 4'd1;
                    if (sample_q == BIT_LAST) begin
                        state_d = IDLE;
                        // Priority: framing, then parity, then overrun.
                        if (rx_s != STOP_LEVEL) begin
                            ferr_d = 1'b1;
                        end else if (par_bad) begin
                            perr_d = 1'b1;
                        end else if (fifo.fifo_full) begin
                            oerr_d = 1'b1;
                        end else begin
                            wr_d   = 1'b1;
                            data_d = shift_q;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            sample_q <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            wr_q     <= 1'b0;
            busy_q   <= 1'b0;
            ferr_q   <= 1'b0;
            oerr_q   <= 1'b0;
            perr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sync1_q  <= rx;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            sample_q <= sample_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            busy_q   <= busy_d;
            ferr_q   <= ferr_d;
            oerr_q   <= oerr_d;
            perr_q   <= perr_d;
`ifdef UART_RX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign fifo.data_out = data_q;
    assign fifo.wr_en    = wr_q;
    assign busy          = busy_q;
    assign frame_err     = ferr_q;
    assign overrun_err   = oerr_q;
    assign parity_err    = perr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level model with an expected-event queue.
// Build with +define+UART_RX_PARITY_EN to exercise the parity path.
module tb_uart_rx;

    localparam int DIVISOR    = 2;
    localparam int DATA_BITS  = 8;
    localparam int PARITY_ODD = 0;
    localparam int BIT_CLKS   = 16 * DIVISOR;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int K_WR   = 0;
    localparam int K_FERR = 1;
    localparam int K_OERR = 2;
    localparam int K_PERR = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic busy, frame_err, overrun_err, parity_err;
    logic rst_at_edge;

    uart_rx_if #(.DATA_BITS(DATA_BITS)) fifo_bus ();

    uart_rx #(
        .DIVISOR   (DIVISOR),
        .DATA_BITS (DATA_BITS),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .fifo       (fifo_bus),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_wr = 0, n_ferr = 0, n_oerr = 0, n_perr = 0;
    exp_t exp_q[$];
    logic [7:0] model_data = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_chk(input int kind, input string name);
        exp_t e;
        chk({name, "_expected"}, int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({name, "_kind"}, e.kind, kind);
            if (kind == K_WR) begin
                chk("wr_data", int'(fifo_bus.data_out), int'(e.data));
                model_data = e.data;
            end
        end
    endtask

    always @(posedge clk) rst_at_edge = rst_n;

    // Compare process: every cycle, pulses must match the queue head.
    always @(negedge clk) begin
        if (!rst_at_edge) begin
            model_data = 8'h00;
            chk("reset_outputs",
                int'({busy, fifo_bus.wr_en, frame_err, overrun_err, parity_err}), 0);
            chk("reset_data", int'(fifo_bus.data_out), 0);
        end else begin
            if (fifo_bus.wr_en) begin
                n_wr++;
                pop_chk(K_WR, "wr");
            end
            if (frame_err) begin
                n_ferr++;
                pop_chk(K_FERR, "ferr");
            end
            if (overrun_err) begin
                n_oerr++;
                pop_chk(K_OERR, "oerr");
            end
            if (parity_err) begin
                n_perr++;
                pop_chk(K_PERR, "perr");
            end
            chk("data_hold", int'(fifo_bus.data_out), int'(model_data));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_bit(input logic b);
        rx = b;
        step(BIT_CLKS);
    endtask

    // Sends one frame with explicit parity bit and predicts its outcome.
    task automatic send_raw(input logic [7:0] d, input logic pb, input logic stop);
        exp_t e;
        logic par_good;
        par_good = (^d) ^ PARITY_ODD[0];
        e.data = d;
        if (!stop) e.kind = K_FERR;
        else if (PAR_EN && pb != par_good) e.kind = K_PERR;
        else if (fifo_bus.fifo_full) e.kind = K_OERR;
        else e.kind = K_WR;
        exp_q.push_back(e);
        put_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) put_bit(d[i]);
        if (PAR_EN) put_bit(pb);
        put_bit(stop);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_raw(d, (^d) ^ PARITY_ODD[0], stop);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step(1);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        fifo_bus.fifo_full = 1'b0;
        rx = 1'b1;
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(10);

        send_frame(8'hA5, 1'b1);
        step(2 * BIT_CLKS);
        drain("drain_a5");
        chk("a5_wr_count", n_wr, 1);
        chk("a5_data", int'(fifo_bus.data_out), 8'hA5);
        chk("a5_errs", n_ferr + n_oerr + n_perr, 0);
        chk("a5_busy", int'(busy), 0);

        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        step(2 * BIT_CLKS);
        drain("drain_b2b");
        chk("b2b_wr_count", n_wr, 3);
        chk("b2b_data", int'(fifo_bus.data_out), 8'hC3);

        send_frame(8'h55, 1'b0);
        step(5 * BIT_CLKS);
        rx = 1'b1;
        step(2 * BIT_CLKS);
        drain("drain_break");
        chk("break_ferr", n_ferr, 1);
        chk("break_wr", n_wr, 3);
        chk("break_busy", int'(busy), 0);

        fifo_bus.fifo_full = 1'b1;
        send_frame(8'h81, 1'b1);
        step(BIT_CLKS);
        fifo_bus.fifo_full = 1'b0;
        drain("drain_ovr");
        chk("ovr_count", n_oerr, 1);
        chk("ovr_wr", n_wr, 3);
        chk("ovr_data", int'(fifo_bus.data_out), 8'hC3);

        rx = 1'b0;
        step(3);
        rx = 1'b1;
        step(5);
        chk("glitch_busy_hi", int'(busy), 1);
        step(2 * BIT_CLKS);
        chk("glitch_busy_lo", int'(busy), 0);
        chk("glitch_pulses", n_wr + n_ferr + n_oerr + n_perr, 5);

        rx = 1'b0;
        step(BIT_CLKS);
        rx = 1'b1;
        step(BIT_CLKS);
        rx = 1'b0;
        step(BIT_CLKS / 2);
        chk("midframe_busy", int'(busy), 1);
        rst_n = 1'b0;
        rx = 1'b1;
        step(1);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_wr", int'(fifo_bus.wr_en), 0);
        chk("mrst_data", int'(fifo_bus.data_out), 0);
        step(2);
        rst_n = 1'b1;
        step(2 * BIT_CLKS);
        chk("mrst_idle", int'(busy), 0);
        chk("mrst_pulses", n_wr + n_ferr + n_oerr + n_perr, 5);

        send_frame(8'h5A, 1'b1);
        step(BIT_CLKS);
        drain("drain_recover");
        chk("recover_data", int'(fifo_bus.data_out), 8'h5A);
        chk("recover_wr", n_wr, 4);

`ifdef UART_RX_PARITY_EN
        send_raw(8'h07, 1'b1, 1'b1);
        step(BIT_CLKS);
        drain("drain_par_ok");
        chk("par_ok_wr", n_wr, 5);
        chk("par_ok_data", int'(fifo_bus.data_out), 8'h07);
        send_raw(8'h07, 1'b0, 1'b1);
        step(BIT_CLKS);
        drain("drain_par_bad");
        chk("par_bad_perr", n_perr, 1);
        chk("par_bad_wr", n_wr, 5);
`endif

        chk("final_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
